// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, ALUOp and control-bundle definitions
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WB_CTL_W = 2;
  localparam int M_CTL_W  = 3;
  localparam int EX_CTL_W = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctl_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctl_t;

  typedef struct packed {
    wb_ctl_t wb;
    m_ctl_t  m;
    ex_ctl_t ex;
  } ctl_t;

  localparam ctl_t CTL_NONE = '0;

  function automatic logic [DATA_W-1:0] sign_extend16(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two async read ports with write-through bypass
module register_file
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] i_ra1,
  input  logic [REG_ADDR_W-1:0] i_ra2,
  output logic [DATA_W-1:0]     o_rd1,
  output logic [DATA_W-1:0]     o_rd2,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0]     i_wd
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // A write landing this edge is forwarded so decode sees the new value.
  always_comb begin
    if (i_ra1 == '0) begin
      o_rd1 = '0;
    end else if (w_wr_en && (i_wa == i_ra1)) begin
      o_rd1 = i_wd;
    end else begin
      o_rd1 = r_regs[i_ra1];
    end
  end

  always_comb begin
    if (i_ra2 == '0) begin
      o_rd2 = '0;
    end else if (w_wr_en && (i_wa == i_ra2)) begin
      o_rd2 = i_wd;
    end else begin
      o_rd2 = r_regs[i_ra2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: IF/ID latch, control decode, register read, ID/EX latch
module id_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     instr_in,
  input  logic [DATA_W-1:0]     npc_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_writereg,
  input  logic [DATA_W-1:0]     wb_writedata,
  output logic [WB_CTL_W-1:0]   wb_ctl,
  output logic [M_CTL_W-1:0]    m_ctl,
  output logic [EX_CTL_W-1:0]   ex_ctl,
  output logic [DATA_W-1:0]     npc_out,
  output logic [DATA_W-1:0]     rd1_out,
  output logic [DATA_W-1:0]     rd2_out,
  output logic [DATA_W-1:0]     signext_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out
);

  logic [DATA_W-1:0]     r_ifid_instr;
  logic [DATA_W-1:0]     r_ifid_npc;

  logic [5:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [15:0]           w_imm;
  ctl_t                  w_ctl;
  logic [DATA_W-1:0]     w_rd1;
  logic [DATA_W-1:0]     w_rd2;
  logic [DATA_W-1:0]     w_signext;

  ctl_t                  r_idex_ctl;
  logic [DATA_W-1:0]     r_idex_npc;
  logic [DATA_W-1:0]     r_idex_rd1;
  logic [DATA_W-1:0]     r_idex_rd2;
  logic [DATA_W-1:0]     r_idex_signext;
  logic [REG_ADDR_W-1:0] r_idex_rt;
  logic [REG_ADDR_W-1:0] r_idex_rd;

  // Flush beats stall: a squashed slot must not survive a hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ifid_instr <= '0;
      r_ifid_npc   <= '0;
    end else if (!stall) begin
      r_ifid_instr <= instr_in;
      r_ifid_npc   <= npc_in;
    end
  end

  assign w_opcode  = r_ifid_instr[31:26];
  assign w_rs      = r_ifid_instr[25:21];
  assign w_rt      = r_ifid_instr[20:16];
  assign w_rd      = r_ifid_instr[15:11];
  assign w_imm     = r_ifid_instr[15:0];
  assign w_signext = sign_extend16(w_imm);

  always_comb begin
    w_ctl = CTL_NONE;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctl.ex.reg_dst   = 1'b1;
        w_ctl.ex.alu_op    = ALUOP_FUNCT;
        w_ctl.wb.reg_write = 1'b1;
      end
      OP_LW: begin
        w_ctl.ex.alu_src    = 1'b1;
        w_ctl.ex.alu_op     = ALUOP_ADD;
        w_ctl.m.mem_read    = 1'b1;
        w_ctl.wb.reg_write  = 1'b1;
        w_ctl.wb.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_ctl.ex.alu_src  = 1'b1;
        w_ctl.ex.alu_op   = ALUOP_ADD;
        w_ctl.m.mem_write = 1'b1;
      end
      OP_BEQ: begin
        w_ctl.m.branch  = 1'b1;
        w_ctl.ex.alu_op = ALUOP_SUB;
      end
      default: begin
        w_ctl = CTL_NONE;
      end
    endcase
  end

  register_file u_register_file (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (wb_regwrite),
    .i_wa  (wb_writereg),
    .i_wd  (wb_writedata)
  );

  // A stall issues a bubble: every ID/EX field is cleared, not just control.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      r_idex_ctl     <= CTL_NONE;
      r_idex_npc     <= '0;
      r_idex_rd1     <= '0;
      r_idex_rd2     <= '0;
      r_idex_signext <= '0;
      r_idex_rt      <= '0;
      r_idex_rd      <= '0;
    end else begin
      r_idex_ctl     <= w_ctl;
      r_idex_npc     <= r_ifid_npc;
      r_idex_rd1     <= w_rd1;
      r_idex_rd2     <= w_rd2;
      r_idex_signext <= w_signext;
      r_idex_rt      <= w_rt;
      r_idex_rd      <= w_rd;
    end
  end

  assign wb_ctl      = r_idex_ctl.wb;
  assign m_ctl       = r_idex_ctl.m;
  assign ex_ctl      = r_idex_ctl.ex;
  assign npc_out     = r_idex_npc;
  assign rd1_out     = r_idex_rd1;
  assign rd2_out     = r_idex_rd2;
  assign signext_out = r_idex_signext;
  assign rt_out      = r_idex_rt;
  assign rd_out      = r_idex_rd;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed and random stimulus
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] npc_in;
  logic        stall;
  logic        flush;
  logic        wb_regwrite;
  logic [4:0]  wb_writereg;
  logic [31:0] wb_writedata;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;
  logic [31:0] npc_out;
  logic [31:0] rd1_out;
  logic [31:0] rd2_out;
  logic [31:0] signext_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .npc_in       (npc_in),
    .stall        (stall),
    .flush        (flush),
    .wb_regwrite  (wb_regwrite),
    .wb_writereg  (wb_writereg),
    .wb_writedata (wb_writedata),
    .wb_ctl       (wb_ctl),
    .m_ctl        (m_ctl),
    .ex_ctl       (ex_ctl),
    .npc_out      (npc_out),
    .rd1_out      (rd1_out),
    .rd2_out      (rd2_out),
    .signext_out  (signext_out),
    .rt_out       (rt_out),
    .rd_out       (rd_out)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sx;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } out_t;

  typedef struct {
    out_t model;
    bit   has_lit;
    out_t lit;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_if_instr;
  logic [31:0] m_if_npc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                              input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] sx, input logic [4:0] rt, input logic [4:0] rd);
    out_t o;
    o.wb = wb; o.m = m; o.ex = ex; o.npc = npc; o.rd1 = rd1; o.rd2 = rd2;
    o.sx = sx; o.rt = rt; o.rd = rd;
    return o;
  endfunction

  function automatic logic [31:0] ref_read(input int idx, input bit we, input int wr, input logic [31:0] wd);
    if (idx == 0) return 32'h0;
    if (we && wr == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic out_t ref_decode(input logic [31:0] instr, input logic [31:0] npc,
                                      input logic [31:0] a, input logic [31:0] b);
    out_t o;
    bit reg_dst = 0, alu_src = 0, reg_write = 0, mem_to_reg = 0;
    bit branch = 0, mem_read = 0, mem_write = 0;
    int alu_op = 0;
    case (int'(instr[31:26]))
      'h00: begin reg_dst = 1; alu_op = 2; reg_write = 1; end
      'h23: begin alu_src = 1; mem_read = 1; reg_write = 1; mem_to_reg = 1; end
      'h2B: begin alu_src = 1; mem_write = 1; end
      'h04: begin branch = 1; alu_op = 1; end
      default: ;
    endcase
    o.wb  = {reg_write, mem_to_reg};
    o.m   = {branch, mem_read, mem_write};
    o.ex  = {reg_dst, 2'(alu_op), alu_src};
    o.npc = npc;
    o.rd1 = a;
    o.rd2 = b;
    o.sx  = {16'h0, instr[15:0]};
    if (instr[15]) o.sx = o.sx - 32'h0001_0000;
    o.rt  = instr[20:16];
    o.rd  = instr[15:11];
    return o;
  endfunction

  task automatic step(input bit rst_v, input bit stall_v, input bit flush_v,
                      input logic [31:0] instr_v, input logic [31:0] npc_v,
                      input bit we_v, input logic [4:0] wr_v, input logic [31:0] wd_v,
                      input bit lit_v, input out_t lit_o);
    exp_t e;
    @(negedge clk);
    #1;
    rst = rst_v; stall = stall_v; flush = flush_v;
    instr_in = instr_v; npc_in = npc_v;
    wb_regwrite = we_v; wb_writereg = wr_v; wb_writedata = wd_v;
    e.has_lit = lit_v;
    e.lit     = lit_o;
    if (rst_v) begin
      e.model = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_if_instr = 32'h0;
      m_if_npc   = 32'h0;
    end else begin
      if (stall_v) e.model = '0;
      else e.model = ref_decode(m_if_instr, m_if_npc,
                                ref_read(int'(m_if_instr[25:21]), we_v, int'(wr_v), wd_v),
                                ref_read(int'(m_if_instr[20:16]), we_v, int'(wr_v), wd_v));
      if (we_v && wr_v != 5'd0) m_regs[wr_v] = wd_v;
      if (flush_v) begin
        m_if_instr = 32'h0;
        m_if_npc   = 32'h0;
      end else if (!stall_v) begin
        m_if_instr = instr_v;
        m_if_npc   = npc_v;
      end
    end
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wb_ctl", 32'(wb_ctl), 32'(e.model.wb));
        chk("m_ctl", 32'(m_ctl), 32'(e.model.m));
        chk("ex_ctl", 32'(ex_ctl), 32'(e.model.ex));
        chk("npc_out", npc_out, e.model.npc);
        chk("rd1_out", rd1_out, e.model.rd1);
        chk("rd2_out", rd2_out, e.model.rd2);
        chk("signext_out", signext_out, e.model.sx);
        chk("rt_out", 32'(rt_out), 32'(e.model.rt));
        chk("rd_out", 32'(rd_out), 32'(e.model.rd));
        if (e.has_lit) begin
          chk("lit_wb_ctl", 32'(wb_ctl), 32'(e.lit.wb));
          chk("lit_m_ctl", 32'(m_ctl), 32'(e.lit.m));
          chk("lit_ex_ctl", 32'(ex_ctl), 32'(e.lit.ex));
          chk("lit_npc_out", npc_out, e.lit.npc);
          chk("lit_rd1_out", rd1_out, e.lit.rd1);
          chk("lit_rd2_out", rd2_out, e.lit.rd2);
          chk("lit_signext_out", signext_out, e.lit.sx);
          chk("lit_rt_out", 32'(rt_out), 32'(e.lit.rt));
          chk("lit_rd_out", 32'(rd_out), 32'(e.lit.rd));
        end
      end
    end
  end

  initial begin : stimulus
    out_t z;
    logic [5:0]  op;
    logic [31:0] ins;
    z = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    instr_in = '0; npc_in = '0;
    wb_regwrite = 1'b0; wb_writereg = '0; wb_writedata = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_if_instr = 32'h0;
    m_if_npc   = 32'h0;

    // reset, then preload $8/$9 and run add / lw / beq
    step(1, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1, z);
    step(0, 0, 0, 32'h0, 32'h0, 1, 5'd8, 32'h0000_00AA, 0, z);
    step(0, 0, 0, 32'h0109_5020, 32'h104, 1, 5'd9, 32'h0000_0055, 0, z);
    step(0, 0, 0, 32'h8D09_FFFC, 32'h108, 0, 5'd0, 32'h0, 1,
         mk(2'b10, 3'b000, 4'b1100, 32'h104, 32'hAA, 32'h55, 32'h0000_5020, 5'd9, 5'd10));
    step(0, 0, 0, 32'h1109_0003, 32'h10C, 0, 5'd0, 32'h0, 1,
         mk(2'b11, 3'b010, 4'b0001, 32'h108, 32'hAA, 32'h55, 32'hFFFF_FFFC, 5'd9, 5'd31));
    // one-cycle stall with beq held in IF/ID
    step(0, 1, 0, 32'hDEAD_BEEF, 32'h0BAD, 0, 5'd0, 32'h0, 1, z);
    step(0, 0, 0, 32'h8D09_FFFC, 32'h110, 0, 5'd0, 32'h0, 1,
         mk(2'b00, 3'b100, 4'b0010, 32'h10C, 32'hAA, 32'h55, 32'h0000_0003, 5'd9, 5'd0));
    // flush together with stall discards the held lw
    step(0, 1, 1, 32'h0109_5020, 32'h200, 0, 5'd0, 32'h0, 1, z);
    step(0, 0, 0, 32'h0109_5020, 32'h114, 0, 5'd0, 32'h0, 1,
         mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0));
    // write-through bypass on $8, and writes to $0 ignored
    step(0, 0, 0, 32'h0, 32'h0, 1, 5'd8, 32'h1234_5678, 1,
         mk(2'b10, 3'b000, 4'b1100, 32'h114, 32'h1234_5678, 32'h55, 32'h0000_5020, 5'd9, 5'd10));
    step(0, 0, 0, 32'h0009_5020, 32'h118, 1, 5'd0, 32'h1234_5678, 0, z);
    step(0, 0, 0, 32'h0, 32'h0, 1, 5'd0, 32'hCAFE_F00D, 1,
         mk(2'b10, 3'b000, 4'b1100, 32'h118, 32'h0, 32'h55, 32'h0000_5020, 5'd9, 5'd10));
    // reset mid-stream overrides stall and write-back
    step(0, 0, 0, 32'h0109_5020, 32'h11C, 0, 5'd0, 32'h0, 0, z);
    step(0, 0, 0, 32'h8D09_FFFC, 32'h120, 0, 5'd0, 32'h0, 0, z);
    step(1, 1, 0, 32'h1109_0003, 32'h0, 1, 5'd9, 32'hFFFF_FFFF, 1, z);
    step(0, 0, 0, 32'h0109_5020, 32'h124, 0, 5'd0, 32'h0, 1,
         mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0));
    step(0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1,
         mk(2'b10, 3'b000, 4'b1100, 32'h124, 32'h0, 32'h0, 32'h0000_5020, 5'd9, 5'd10));

    // random traffic, small register indices so bypass and hazards recur
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           ins, $urandom, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom, 0, z);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
    end
    chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
